// File: rtl/ng_imem_pkg.sv
// Shared types and constants for the nandgame instruction memory and its loader.
package ng_imem_pkg;

    typedef enum logic [2:0] {
        HALT,
        LEN_LO,
        LEN_HI,
        DATA_LO,
        DATA_HI,
        RUN
    } state_t;

    localparam logic [15:0] NOP_WORD = 16'h0000;

endpackage

// File: rtl/ng_imem_array.sv
// DEPTH x 16 instruction storage: synchronous write, asynchronous read, no reset.
module ng_imem_array
    import ng_imem_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [15:0]       i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [15:0]       o_rdata
);

    logic [15:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ng_imem_loader.sv
// Instruction memory with a byte-serial program loader; the core is held in reset
// while a program is streamed in and released once the last word lands.
module ng_imem_loader
    import ng_imem_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [15:0]     i_addr,
    output logic [15:0]     o_instruction,
    output logic            o_core_rst,
    input  logic            i_load_start,
    input  logic            i_run,
    input  logic [7:0]      i_byte_data,
    input  logic            i_byte_valid,
    output logic            o_byte_ready,
    output logic            o_busy,
    output logic            o_err,
    output logic [ADDR_W:0] o_words_loaded
);

    localparam logic [15:0]     DEPTH_16 = 16'(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_W  = (ADDR_W + 1)'(DEPTH);

    state_t            r_state;
    logic [7:0]        r_len_lo;
    logic [7:0]        r_data_lo;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_words;
    logic [ADDR_W-1:0] r_index;
    logic              r_core_rst;
    logic              r_err;

    logic              w_load_state;
    logic              w_xfer;
    logic [15:0]       w_len;
    logic              w_we;
    logic [15:0]       w_wdata;
    logic [15:0]       w_rdata;
    logic              w_last_word;

    assign w_load_state = (r_state == LEN_LO) || (r_state == LEN_HI) ||
                          (r_state == DATA_LO) || (r_state == DATA_HI);
    assign w_xfer       = w_load_state && i_byte_valid;
    assign w_len        = {i_byte_data, r_len_lo};
    assign w_wdata      = {i_byte_data, r_data_lo};
    assign w_last_word  = ((r_words + 1'b1) == r_len);

    // A coincident load_start wins, so the byte it collides with must not be written.
    assign w_we = w_xfer && (r_state == DATA_HI) && !i_load_start;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= HALT;
            r_len_lo   <= 8'h00;
            r_data_lo  <= 8'h00;
            r_len      <= '0;
            r_words    <= '0;
            r_index    <= '0;
            r_core_rst <= 1'b0;
            r_err      <= 1'b0;
        end else if (i_load_start) begin
            r_state    <= LEN_LO;
            r_words    <= '0;
            r_index    <= '0;
            r_core_rst <= 1'b0;
        end else begin
            case (r_state)
                HALT: begin
                    if (i_run) begin
                        r_state    <= RUN;
                        r_core_rst <= 1'b1;
                    end
                end
                LEN_LO: begin
                    if (w_xfer) begin
                        r_len_lo <= i_byte_data;
                        r_state  <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (w_xfer) begin
                        if (w_len == 16'h0000) begin
                            r_state    <= RUN;
                            r_core_rst <= 1'b1;
                        end else if (w_len > DEPTH_16) begin
                            r_err   <= 1'b1;
                            r_state <= HALT;
                        end else begin
                            r_len   <= w_len[ADDR_W:0];
                            r_state <= DATA_LO;
                        end
                    end
                end
                DATA_LO: begin
                    if (w_xfer) begin
                        r_data_lo <= i_byte_data;
                        r_state   <= DATA_HI;
                    end
                end
                DATA_HI: begin
                    if (w_xfer) begin
                        r_index <= r_index + 1'b1;
                        r_words <= (r_words == DEPTH_W) ? r_words : r_words + 1'b1;
                        if (w_last_word) begin
                            r_state    <= RUN;
                            r_core_rst <= 1'b1;
                        end else begin
                            r_state <= DATA_LO;
                        end
                    end
                end
                RUN: begin
                    r_state <= RUN;
                end
                default: begin
                    r_state    <= HALT;
                    r_core_rst <= 1'b0;
                end
            endcase
        end
    end

    ng_imem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr (r_index),
        .i_wdata (w_wdata),
        .i_raddr (i_addr[ADDR_W-1:0]),
        .o_rdata (w_rdata)
    );

    // Out-of-range fetches return a NOP rather than aliasing onto low memory.
    assign o_instruction  = (i_addr < DEPTH_16) ? w_rdata : NOP_WORD;
    assign o_core_rst     = r_core_rst;
    assign o_byte_ready   = w_load_state;
    assign o_busy         = w_load_state;
    assign o_err          = r_err;
    assign o_words_loaded = r_words;

endmodule

// File: tb/tb_ng_imem_loader.sv
// Self-checking bench for ng_imem_loader: table-driven fetch vectors, hand-written
// restart/reset sequences and randomized program loads against a memory model.
module tb_ng_imem_loader;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr = 16'h0000;
    logic [15:0] instruction;
    logic        coreRst;
    logic        loadStart = 1'b0;
    logic        runPulse = 1'b0;
    logic [7:0]  byteData = 8'h00;
    logic        byteValid = 1'b0;
    logic        byteReady;
    logic        busy;
    logic        err;
    logic [8:0]  wordsLoaded;

    int checks = 0;
    int errors = 0;

    logic [15:0] mdl [DEPTH];
    bit          expErr = 1'b0;
    logic [15:0] progQ [$];

    typedef struct {
        logic [15:0] addr;
        logic [15:0] expInstr;
    } fetchVec_t;

    fetchVec_t fetchTab [6];

    ng_imem_loader #(
        .DEPTH  (256),
        .ADDR_W (8)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_addr         (addr),
        .o_instruction  (instruction),
        .o_core_rst     (coreRst),
        .i_load_start   (loadStart),
        .i_run          (runPulse),
        .i_byte_data    (byteData),
        .i_byte_valid   (byteValid),
        .o_byte_ready   (byteReady),
        .o_busy         (busy),
        .o_err          (err),
        .o_words_loaded (wordsLoaded)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Sends one byte after an optional idle gap; called and returns at a falling edge.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        repeat (gap) begin
            byteValid = 1'b0;
            byteData  = 8'($urandom);
            @(negedge clk);
        end
        byteData  = b;
        byteValid = 1'b1;
        #1;
        checkOutput("byte_ready", 32'(byteReady), 32'd1);
        @(negedge clk);
        byteValid = 1'b0;
    endtask

    task automatic fetchCheck(input logic [15:0] a);
        logic [15:0] exp;
        addr = a;
        #1;
        exp = (a < 16'(DEPTH)) ? mdl[a[7:0]] : 16'h0000;
        checkOutput($sformatf("fetch_%0h", a), 32'(instruction), 32'(exp));
        @(negedge clk);
    endtask

    task automatic pulseLoadStart();
        loadStart = 1'b1;
        @(negedge clk);
        loadStart = 1'b0;
        checkOutput("load_busy", 32'(busy), 32'd1);
        checkOutput("load_core_rst", 32'(coreRst), 32'd0);
        checkOutput("load_words_clr", 32'(wordsLoaded), 32'd0);
    endtask

    function automatic int pickGap(input int maxGap);
        return (maxGap == 0) ? 0 : int'($urandom_range(maxGap, 0));
    endfunction

    task automatic fillProg(input int n);
        progQ.delete();
        for (int i = 0; i < n; i++) progQ.push_back(16'($urandom));
    endtask

    // Full load of header n and, if legal, the first n words of progQ, then checks results.
    task automatic loadProgram(input logic [15:0] n, input int maxGap);
        bit legal;
        legal = (n <= 16'(DEPTH));
        pulseLoadStart();
        applyStimulus(n[7:0], pickGap(maxGap));
        applyStimulus(n[15:8], pickGap(maxGap));
        if (!legal) begin
            expErr = 1'b1;
        end else begin
            for (int i = 0; i < int'(n); i++) begin
                applyStimulus(progQ[i][7:0], pickGap(maxGap));
                applyStimulus(progQ[i][15:8], pickGap(maxGap));
                mdl[i] = progQ[i];
            end
        end
        checkOutput("end_core_rst", 32'(coreRst), 32'(legal));
        checkOutput("end_busy", 32'(busy), 32'd0);
        checkOutput("end_byte_ready", 32'(byteReady), 32'd0);
        checkOutput("end_err", 32'(err), 32'(expErr));
        checkOutput("end_words", 32'(wordsLoaded), legal ? 32'(n) : 32'd0);
        if (legal) begin
            for (int i = 0; i < int'(n); i++) fetchCheck(16'(i));
        end
    endtask

    initial begin
        logic [15:0] w0;
        logic [15:0] w1old;
        logic [8:0]  keepWords;

        fetchTab[0] = '{16'h0001, 16'h5678};
        fetchTab[1] = '{16'h0000, 16'h1234};
        fetchTab[2] = '{16'h0100, 16'h0000};
        fetchTab[3] = '{16'h012C, 16'h0000};
        fetchTab[4] = '{16'hFFFF, 16'h0000};
        fetchTab[5] = '{16'h8001, 16'h0000};

        // Reset state and the HALT -> RUN release
        repeat (2) @(negedge clk);
        checkOutput("rst_core_rst", 32'(coreRst), 32'd0);
        checkOutput("rst_byte_ready", 32'(byteReady), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_words", 32'(wordsLoaded), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("idle_core_rst", 32'(coreRst), 32'd0);
        checkOutput("idle_byte_ready", 32'(byteReady), 32'd0);
        runPulse = 1'b1;
        @(negedge clk);
        runPulse = 1'b0;
        checkOutput("run_core_rst", 32'(coreRst), 32'd1);
        checkOutput("run_busy", 32'(busy), 32'd0);

        // Basic two-word load and the fetch vector table
        progQ = '{16'h1234, 16'h5678};
        loadProgram(16'd2, 0);
        for (int i = 0; i < 6; i++) begin
            addr = fetchTab[i].addr;
            #1;
            checkOutput($sformatf("fetch_tab_%0d", i), 32'(instruction), 32'(fetchTab[i].expInstr));
            @(negedge clk);
        end

        // Oversized header sets err and leaves memory alone; N=0 then releases the core
        loadProgram(16'h0101, 0);
        loadProgram(16'h0000, 0);
        checkOutput("err_sticky", 32'(err), 32'd1);
        fetchCheck(16'h0000);
        fetchCheck(16'h0001);

        // Mid-load restart, with a byte coinciding with load_start and a stray run pulse
        pulseLoadStart();
        applyStimulus(8'h03, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'hAA, 0);
        applyStimulus(8'hBB, 0);
        mdl[0] = 16'hBBAA;
        checkOutput("restart_words1", 32'(wordsLoaded), 32'd1);
        fetchCheck(16'h0000);
        loadStart = 1'b1;
        runPulse  = 1'b1;
        byteValid = 1'b1;
        byteData  = 8'hEE;
        @(negedge clk);
        loadStart = 1'b0;
        runPulse  = 1'b0;
        byteValid = 1'b0;
        checkOutput("restart_busy", 32'(busy), 32'd1);
        checkOutput("restart_words0", 32'(wordsLoaded), 32'd0);
        runPulse = 1'b1;
        @(negedge clk);
        runPulse = 1'b0;
        checkOutput("run_ignored", 32'(coreRst), 32'd0);
        applyStimulus(8'h01, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'hCD, 0);
        applyStimulus(8'hAB, 0);
        mdl[0] = 16'hABCD;
        checkOutput("restart_core_rst", 32'(coreRst), 32'd1);
        checkOutput("restart_words", 32'(wordsLoaded), 32'd1);
        fetchCheck(16'h0000);
        fetchCheck(16'h0001);

        // Randomized loads with idle gaps, then the same program gapless
        fillProg(4);
        loadProgram(16'd4, 5);
        loadProgram(16'd4, 0);
        for (int k = 0; k < 3; k++) begin
            int n;
            n = int'($urandom_range(24, 1));
            fillProg(n);
            loadProgram(16'(n), 3);
        end

        // Bytes offered while running are not accepted
        keepWords = wordsLoaded;
        for (int i = 0; i < 4; i++) begin
            byteValid = 1'b1;
            byteData  = 8'($urandom);
            #1;
            checkOutput("run_no_ready", 32'(byteReady), 32'd0);
            @(negedge clk);
        end
        byteValid = 1'b0;
        checkOutput("run_words_hold", 32'(wordsLoaded), 32'(keepWords));
        for (int i = 0; i < 4; i++) fetchCheck(16'(i));

        // Full-depth load at the size boundary
        fillProg(DEPTH);
        loadProgram(16'd256, 0);
        fetchCheck(16'h0100);
        fetchCheck(16'hFFFF);

        // Asynchronous reset while in DATA_HI
        fillProg(3);
        w0    = progQ[0];
        w1old = mdl[1];
        pulseLoadStart();
        applyStimulus(8'h03, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(w0[7:0], 0);
        applyStimulus(w0[15:8], 0);
        mdl[0] = w0;
        applyStimulus(progQ[1][7:0], 0);
        rst = 1'b1;
        #1;
        expErr = 1'b0;
        checkOutput("arst_core_rst", 32'(coreRst), 32'd0);
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_byte_ready", 32'(byteReady), 32'd0);
        checkOutput("arst_err", 32'(err), 32'd0);
        checkOutput("arst_words", 32'(wordsLoaded), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("arst_halt_busy", 32'(busy), 32'd0);
        checkOutput("arst_halt_core", 32'(coreRst), 32'd0);
        fetchCheck(16'h0000);
        addr = 16'h0001;
        #1;
        checkOutput("arst_keep_w1", 32'(instruction), 32'(w1old));
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ng_imem_loader.md
Name: ng_imem_loader

Overview:
- Instruction memory plus byte-serial program loader that serves the nandgame core's fetch port.
- The core drives a 16-bit fetch address. This block returns the 16-bit instruction combinationally in the same cycle.
- A byte-stream valid/ready loader writes a program into the array while the block holds the core in reset. The core is released when loading completes.

Parameters:
- DEPTH, 256, number of 16-bit instruction words.
- ADDR_W, 8, index width; must equal clog2(DEPTH).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- addr  input  16  fetch address from the core
- instruction  output  16  instruction word returned to the core
- core_rst  output  1  active-low reset to the core; 0 = core held
- load_start  input  1  one-cycle pulse; begins a program load
- run  input  1  one-cycle pulse; releases the core without loading (HALT only)
- byte_data  input  8  loader byte
- byte_valid  input  1  byte_data is valid
- byte_ready  output  1  block accepts a byte this cycle
- busy  output  1  1 in any load state
- err  output  1  sticky; set when the length header exceeds DEPTH
- words_loaded  output  ADDR_W+1  data words written in the current or last load

Behaviour:
- States:
  - HALT: core held, idle.
  - LEN_LO, LEN_HI: receive the 16-bit word count N, little-endian.
  - DATA_LO, DATA_HI: receive each data word, low byte then high byte.
  - RUN: core released.
- Reset (async, rst=1):
  - State = HALT.
  - core_rst=0, byte_ready=0, busy=0, err=0, words_loaded=0.
  - Internal counters cleared.
  - Memory array is NOT reset; contents persist.
- Byte transfer occurs on a rising edge with byte_valid && byte_ready.
  - byte_ready = 1 exactly in LEN_LO, LEN_HI, DATA_LO, DATA_HI.
  - byte_ready does not depend on byte_valid.
- Transitions:
  - load_start in any state → LEN_LO at the next edge. Clears words_loaded and the write index. Does not clear err. Restart mid-load is allowed.
  - HALT + run → RUN. run is ignored in all other states.
  - LEN_LO + transfer: latch the low byte of N → LEN_HI.
  - LEN_HI + transfer: form N.
    - N==0 → RUN; memory unchanged.
    - N>DEPTH → set err → HALT; memory unchanged.
    - Otherwise → DATA_LO.
  - DATA_LO + transfer: latch the low byte → DATA_HI.
  - DATA_HI + transfer: write {byte_data, low_byte} to mem[index]; increment index and words_loaded.
    - If words_loaded+1 == N → RUN.
    - Otherwise → DATA_LO.
- Simultaneous events: load_start has priority over a coincident byte transfer; that byte is discarded.
- Memory write timing: synchronous, on the DATA_HI transfer edge. Write and fetch of the same index in one cycle cannot occur, because the core is held during load.
- Fetch (combinational, no latency):
  - addr < DEPTH → instruction = mem[addr[ADDR_W-1:0]].
  - Otherwise → instruction = 16'h0000. No wrap-around.
- core_rst:
  - Registered; 1 only in RUN.
  - Goes 0 on the same edge that enters LEN_LO.
  - Goes 1 on the edge that enters RUN, so the core restarts at address 0.
- busy = 1 in LEN_LO, LEN_HI, DATA_LO, DATA_HI.
- words_loaded saturates at DEPTH and holds its value after the load ends.

Decomposition:
- Package ng_imem_pkg:
  - State enum typedef (HALT, LEN_LO, LEN_HI, DATA_LO, DATA_HI, RUN).
  - Constant NOP_WORD = 16'h0000.
- One sub-module, ng_imem_array:
  - DEPTH x 16 storage.
  - Synchronous write port (we, waddr, wdata).
  - Asynchronous read port (raddr, rdata).
  - No reset.
- The FSM, byte assembly and fetch-range check live in the top module.

Test Plan:
- Reset then idle → core_rst=0, byte_ready=0, err=0; run pulse → core_rst=1 after one edge.
- load_start, bytes 02 00 34 12 78 56 → mem[0]=16'h1234, mem[1]=16'h5678, words_loaded=2, state RUN, core_rst=1. Then addr=1 → instruction=16'h5678 same cycle; addr=300 → 16'h0000.
- load_start, header 0x0101 (257 > 256) → err=1, HALT, core_rst=0; memory unchanged, checked by reloading N=0 and fetching.
- Mid-load restart: header 03 00, one word AA BB, then load_start and header 01 00, word CD AB → mem[0]=16'hABCD, words_loaded=1, RUN.
- Backpressure/gaps: byte_valid toggled randomly with 0–5 idle cycles between bytes for N=4 → contents identical to gapless load; no byte accepted while byte_ready=0.
- Async reset mid-load (rst in DATA_HI) → immediate core_rst=0, busy=0; previously written words retained.
